imem_fetch: RTL and testbench
=============================

# imem_fetch

Parametrised, clocked instruction memory with a valid/ready fetch port, a program-load write port, a flush for redirects, and out-of-range fault reporting instead of halting simulation. Sits between the PC/fetch stage and decode in the RISC CPU. It replaces the combinational, fixed 32x32 instruction store with a one-cycle registered read. Responses are held until decode accepts them.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- DEPTH, 32, number of instruction words; any value from 2 to 2^ADDR_W
- ADDR_W, 32, fetch/write address width; word-addressed
- FAULT_CNT_W, 8, width of the saturating fault counter

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_addr  in  ADDR_W  word address to fetch
- rsp_valid  out  1  response held in the output register
- rsp_ready  in  1  decode accepts the response
- rsp_data  out  DATA_W  fetched instruction; all-zero (NOP) on fault
- rsp_fault  out  1  response address was >= DEPTH
- flush  in  1  discard the held response (branch/jump redirect)
- wr_en  in  1  program-load write strobe
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- fault_cnt  out  FAULT_CNT_W  count of faulting accepted requests; saturates at all-ones

## Operation
- Storage is DEPTH x DATA_W. Contents are not reset. Unwritten words read as X in simulation.
- The output buffer is a single register slot with state EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- req_ready = !rsp_valid || rsp_ready || flush. This is combinational and lets requests stream back-to-back.
- An accepted request (req_valid && req_ready) loads the slot on the next edge:
  - if req_addr < DEPTH: rsp_data = mem[req_addr], rsp_fault = 0
  - otherwise: rsp_data = 0, rsp_fault = 1, and fault_cnt increments unless it is saturated
- Slot transitions:
  - EMPTY to FULL on an accepted request.
  - FULL to EMPTY when rsp_ready or flush is high and there is no accepted request.
  - FULL to FULL (reloaded) when the held response drains or is flushed in the same cycle a request is accepted.
  - FULL holds its data unchanged while rsp_ready=0 and flush=0. rsp_data and rsp_fault must not change while stalled.
- flush with no request empties the slot. flush together with an accepted request keeps only the new response, because the redirect target is fetched in the same cycle.
- Writes: if wr_en && wr_addr < DEPTH, then mem[wr_addr] = wr_data on the edge. Out-of-range writes are ignored and do not count as faults.
- Read/write collision on the same address in the same cycle returns the old word (read-before-write). The new word is visible to requests accepted on the following cycle.
- Comparisons against DEPTH are unsigned and use the full ADDR_W. Upper address bits are never truncated, so no aliasing occurs.

## Timing
- Reset (asynchronous assert, synchronous-edge release): rsp_valid=0, rsp_data=0, rsp_fault=0, fault_cnt=0. req_ready=1 during and after reset.
- Latency: a request accepted at edge N produces rsp_valid=1 with its data after edge N.
- Throughput: one fetch per cycle while rsp_ready=1.
- Reset asserted mid-operation immediately clears the held response and fault_cnt. Memory contents survive reset.
- No combinational path exists from req_addr to rsp_data. The only combinational input-to-output paths are rsp_ready and flush to req_ready.

## Test plan
- Load words 0..31 with 0x1000_0000+i via the write port, then stream req_addr 0..31 with rsp_ready=1. Required: rsp_data=0x1000_0000+i one cycle after each request, 32 back-to-back responses, fault_cnt=0.
- Request address 5, then hold rsp_ready=0 for 4 cycles while req_valid=1 with address 6. Required: req_ready=0, rsp_data stays 0x1000_0005, then 0x1000_0006 follows the cycle after rsp_ready rises.
- With DEPTH=32, request 32 and then 0xFFFF_FFFF. Required: rsp_fault=1 with rsp_data=0 for both, fault_cnt=2. Then request 0x0000_0100 and send 300 total faulting requests with FAULT_CNT_W=8; fault_cnt saturates at 255.
- Stall a held response for address 3, then assert flush together with req_valid at address 26. Required: the address-3 response never handshakes, and the next response is mem[26].
- Write 0xDEAD_BEEF to address 7 in the same cycle as a fetch of address 7 (old value 0x1000_0007). Required: response 0x1000_0007, and an immediate re-fetch returns 0xDEAD_BEEF. A write to address 40 is ignored.
- Assert rst_n=0 asynchronously while rsp_valid=1 and fault_cnt=3. Required: rsp_valid, rsp_data, rsp_fault and fault_cnt go to 0 without a clock edge, and a fetch of address 7 after release still returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch: clocked instruction memory between the fetch stage and decode.
//
// A DEPTH x DATA_W word store is written through a program-load port and read
// through a valid/ready fetch port. Each accepted fetch loads a single
// registered response slot one cycle later. The slot is held until decode
// accepts it or a redirect flushes it. Out-of-range fetches return an all-zero
// NOP with rsp_fault set and bump a saturating fault counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake, req_addr = word address
//   rsp_valid/rsp_ready   response handshake, rsp_data/rsp_fault payload
//   flush                 discard the held response (redirect)
//   wr_en/wr_addr/wr_data program-load write port
//   fault_cnt             saturating count of faulting accepted fetches
module imem_fetch #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 32,
    parameter int FAULT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_fault,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [FAULT_CNT_W-1:0] fault_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2^ADDR_W is representable; the compare uses
    // the full address so high bits never alias onto valid words.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [FAULT_CNT_W-1:0] CNT_MAX = {FAULT_CNT_W{1'b1}};

    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rsp_data_r;
    logic                   rsp_fault_r;
    logic [FAULT_CNT_W-1:0] fault_cnt_r;

    logic                   req_ready_s;
    logic                   accept_s;
    logic                   rd_in_range_s;
    logic                   wr_in_range_s;
    logic                   drain_s;

    // Handshake and range decode; only rsp_ready/flush reach req_ready combinationally.
    always_comb begin
        req_ready_s   = 1'b1;
        accept_s      = 1'b0;
        rd_in_range_s = 1'b0;
        wr_in_range_s = 1'b0;
        drain_s       = 1'b0;
        if (rsp_valid_r) begin
            req_ready_s = rsp_ready | flush;
        end else begin
            req_ready_s = 1'b1;
        end
        accept_s      = req_valid & req_ready_s;
        rd_in_range_s = ({1'b0, req_addr} < DEPTH_EXT);
        wr_in_range_s = ({1'b0, wr_addr} < DEPTH_EXT);
        drain_s       = rsp_valid_r & (rsp_ready | flush);
    end

    // Program-load write port; storage is deliberately not reset so a loaded
    // program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range_s) begin
            mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Response slot: load on accept (reading the pre-write word), empty on
    // drain/flush, otherwise hold payload stable for a stalled decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_fault_r <= 1'b0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            if (rd_in_range_s) begin
                rsp_data_r  <= mem_r[req_addr[IDX_W-1:0]];
                rsp_fault_r <= 1'b0;
            end else begin
                rsp_data_r  <= {DATA_W{1'b0}};
                rsp_fault_r <= 1'b1;
            end
        end else if (drain_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    // Saturating count of accepted out-of-range fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_cnt_r <= {FAULT_CNT_W{1'b0}};
        end else if (accept_s && !rd_in_range_s && (fault_cnt_r != CNT_MAX)) begin
            fault_cnt_r <= fault_cnt_r + FAULT_CNT_W'(1);
        end else begin
            fault_cnt_r <= fault_cnt_r;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_fault = rsp_fault_r;
    assign fault_cnt = fault_cnt_r;

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: the stimulus side pushes the expected
// response of every accepted fetch; a negedge monitor compares the held slot,
// req_ready and fault_cnt against the reference and pops on handshake/flush.
module tb_imem_fetch;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 32;
    localparam int FW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_fault;
    logic          flush;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [FW-1:0] fault_cnt;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fault;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            fault_total = 0;
    int            errors = 0;
    int            checks = 0;

    imem_fetch #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .FAULT_CNT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [63:0] exp_cnt();
        return (fault_total > 255) ? 64'd255 : 64'(fault_total);
    endfunction

    // Monitor: compare against the scoreboard head, then retire it if decode
    // takes it or a flush discards it at the coming edge.
    always @(negedge clk) begin
        logic occ;
        rsp_t dummy;
        occ = (exp_q.size() != 0);
        check("rsp_valid", 64'(rsp_valid), 64'(occ));
        check("req_ready", 64'(req_ready), 64'(!occ || rsp_ready || flush));
        check("fault_cnt", 64'(fault_cnt), exp_cnt());
        if (occ) begin
            check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
            check("rsp_fault", 64'(rsp_fault), 64'(exp_q[0].fault));
            if (rsp_ready || flush) dummy = exp_q.pop_front();
        end
    end

    // One cycle of stimulus; entered and left at posedge+1.
    task automatic cyc(input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic fl, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        req_valid = rv; req_addr = ra; rsp_ready = rr; flush = fl;
        wr_en = we; wr_addr = wa; wr_data = wd;
        #6;
        // Slot is free if empty, or if the monitor just retired its head.
        if (rv && (exp_q.size() == 0 || rr || fl)) begin
            if (ra < 32'(DEPTH)) begin
                exp_q.push_back('{data: ref_mem[ra], fault: 1'b0});
            end else begin
                exp_q.push_back('{data: 32'h0, fault: 1'b1});
                fault_total++;
            end
        end
        if (we && wa < 32'(DEPTH)) ref_mem[wa] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] ra, input logic rr);
        cyc(1'b1, ra, rr, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic async_reset();
        req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0; wr_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        check("rst_fault_cnt", 64'(fault_cnt), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        exp_q.delete();
        fault_total = 0;
        @(posedge clk);
        #1;
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0; flush = 1'b0;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
        @(posedge clk);
        #1;
        check("init_rsp_valid", 64'(rsp_valid), 64'd0);
        check("init_rsp_data", 64'(rsp_data), 64'd0);
        check("init_rsp_fault", 64'(rsp_fault), 64'd0);
        check("init_fault_cnt", 64'(fault_cnt), 64'd0);
        check("init_req_ready", 64'(req_ready), 64'd1);
        idle(1'b0);
        rst_n = 1'b1;
        idle(1'b0);

        // Program load, then 32 back-to-back fetches.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < DEPTH; i++) fetch(32'(i), 1'b1);
        idle(1'b1);

        // Stall: address 5 held while address 6 waits.
        fetch(32'd5, 1'b0);
        for (int i = 0; i < 4; i++) fetch(32'd6, 1'b0);
        fetch(32'd6, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Faults and saturation: 300 faulting fetches in total.
        fetch(32'd32, 1'b1);
        fetch(32'hFFFF_FFFF, 1'b1);
        fetch(32'h0000_0100, 1'b1);
        for (int i = 3; i < 300; i++) fetch(32'($urandom_range(32, 32'h7FFF_FFFF)), 1'b1);
        idle(1'b1);
        check("sat_fault_cnt", 64'(fault_cnt), 64'd255);

        // Flush of a stalled response together with a redirect fetch.
        fetch(32'd3, 1'b0);
        idle(1'b0);
        cyc(1'b1, 32'd26, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Read-before-write collision, re-fetch, ignored out-of-range write.
        cyc(1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd7, 32'hDEAD_BEEF);
        fetch(32'd7, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd40, 32'h1234_5678);
        fetch(32'd8, 1'b1);
        idle(1'b1);

        // Async reset with a held response and fault_cnt=3; memory survives.
        async_reset();
        for (int i = 0; i < 3; i++) fetch(32'd40 + 32'(i), 1'b1);
        fetch(32'd9, 1'b0);
        idle(1'b0);
        check("pre_rst_fault_cnt", 64'(fault_cnt), 64'd3);
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        async_reset();
        fetch(32'd7, 1'b1);
        idle(1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                32'($urandom_range(0, 40)), 32'($urandom));
        end
        idle(1'b1);
        idle(1'b1);
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
